// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers for stream_fifo and its pointer counters.
package stream_fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A single-entry FIFO still needs a 1-bit pointer to index its storage.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: wraps on an explicit compare so non power-of-two
// depths index only valid storage entries.
module wrap_ptr
    import stream_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy, thresholds and flush.
// Optional high-water mark register enabled by defining STREAM_FIFO_HWM_EN.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1,
    localparam int CNT_W    = cnt_width(DEPTH),
    localparam int PTR_W    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] hwm
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Handshakes are forced low while reset is held, whatever the stale count.
    assign in_ready  = reset_n && (count_reg != CNT_W'(DEPTH));
    assign out_valid = reset_n && (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; a word pushed in a flush cycle is dropped.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign out_data     = mem[rd_ptr];
    assign count        = count_reg;
    assign almost_full  = int'(count_reg) >= AFULL_TH;
    assign almost_empty = int'(count_reg) <= AEMPTY_TH;

`ifdef STREAM_FIFO_HWM_EN
    logic [CNT_W-1:0] hwm_reg;

    // count_next never exceeds DEPTH, so the mark saturates on its own.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hwm_reg <= '0;
        end else if (flush) begin
            hwm_reg <= '0;
        end else if (count_next > hwm_reg) begin
            hwm_reg <= count_next;
        end
    end

    assign hwm = hwm_reg;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo (DEPTH=5, WIDTH=8); follows STREAM_FIFO_HWM_EN.
module tb_stream_fifo;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 5;
    localparam int AFULL_TH  = DEPTH - 1;
    localparam int AEMPTY_TH = 1;
    localparam int CNT_W     = 3;
`ifdef STREAM_FIFO_HWM_EN
    localparam bit HWM_EN = 1'b1;
`else
    localparam bit HWM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] hwm;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] sb_q [$];
    int               m_cnt = 0;
    int               m_hwm = 0;

    stream_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .hwm          (hwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: check outputs against the model, take the edge, update the model.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                         input logic fl, input logic rn);
        logic exp_ready;
        logic exp_valid;
        logic do_push;
        logic do_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset_n   = rn;
        #1;
        exp_ready = rn && (m_cnt != DEPTH);
        exp_valid = rn && (m_cnt != 0);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("count", 32'(count), m_cnt);
        check("almost_full", 32'(almost_full), 32'(m_cnt >= AFULL_TH));
        check("almost_empty", 32'(almost_empty), 32'(m_cnt <= AEMPTY_TH));
        check("hwm", 32'(hwm), HWM_EN ? m_hwm : 0);
        if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(sb_q[0]));
        end
        do_push = iv && exp_ready;
        do_pop  = ordy && exp_valid;
        @(posedge clk);
        #1;
        if (!rn || fl) begin
            sb_q.delete();
            m_hwm = 0;
        end else begin
            if (do_pop) begin
                void'(sb_q.pop_front());
            end
            if (do_push) begin
                sb_q.push_back(d);
            end
        end
        m_cnt = sb_q.size();
        if (HWM_EN && m_cnt > m_hwm) begin
            m_hwm = m_cnt;
        end
        $display("txn t=%0t rn=%0b fl=%0b push=%0b data=0x%0h pop=%0b model_count=%0d",
                 $time, rn, fl, (do_push && rn && !fl), d, (do_pop && rn && !fl), m_cnt);
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 8'(base + i), 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1 && m_cnt > 0; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Fill to full with the consumer stalled, then try one more push.
        push_n(5, 8'h10);
        cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        drain();

        // Alternating push/pop: pointers wrap twice, count stays <= 1.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end

        // Simultaneous push and pop at count 2.
        push_n(2, 8'h21);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        drain();

        // Full FIFO with both sides active: pop only.
        push_n(5, 8'h30);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // Flush with a concurrent push, then confirm old data is gone.
        push_n(3, 8'h50);
        cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_n(1, 8'h66);
        drain();

        // Reset mid-burst, held for two cycles.
        push_n(3, 8'h60);
        cycle(1'b1, 8'h57, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h58, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_n(1, 8'h67);
        drain();

        // High-water mark: fill to 4, drain to 1, then flush.
        push_n(4, 8'h80);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
